seq_encoder_16to4: RTL and testbench



---
 rtl/seq_encoder_16to4_pkg.sv | 42 ++++
 rtl/seq_encoder_16to4_ffs_encoder.sv | 19 +
 rtl/seq_encoder_16to4.sv | 93 +++++++++
 tb/tb_seq_encoder_16to4.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_encoder_16to4_pkg.sv
// Shared types and helpers for the sequential 16-to-4 line encoder.
// The helpers work on a fixed wide vector so that any WIDTH up to MAX_W can use them.
package seq_encoder_16to4_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  localparam int unsigned MAX_W = 256;
  typedef logic [MAX_W-1:0] wide_t;

  function automatic int unsigned code_w(input int unsigned w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

  function automatic int unsigned popcount(input wide_t v);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      if (v[i]) n++;
    end
    return n;
  endfunction

  // Returns 0 for an all-zero vector; callers qualify with an any-set flag.
  function automatic int unsigned ffs(input wide_t v, input logic lsb_first);
    int unsigned idx;
    idx = 0;
    if (lsb_first) begin
      for (int unsigned i = MAX_W; i > 0; i--) begin
        if (v[i-1]) idx = i - 1;
      end
    end else begin
      for (int unsigned i = 0; i < MAX_W; i++) begin
        if (v[i]) idx = i;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/seq_encoder_16to4_ffs_encoder.sv
// Combinational WIDTH-line priority encoder with selectable search direction.
module ffs_encoder
  import seq_encoder_16to4_pkg::*;
#(
  parameter  int unsigned WIDTH  = 16,
  localparam int unsigned CODE_W = code_w(WIDTH)
) (
  input  logic [WIDTH-1:0]  word,
  input  logic              lsb_first,
  output logic [CODE_W-1:0] code,
  output logic              any
);

  always_comb begin
    code = CODE_W'(ffs(wide_t'(word), lsb_first));
    any  = |word;
  end

endmodule

// File: rtl/seq_encoder_16to4.sv
// Sequential line-to-code encoder: accepts a request word, then emits the index
// of every set bit as one handshake beat each, flagging the final beat.
module seq_encoder_16to4
  import seq_encoder_16to4_pkg::*;
#(
  parameter  int unsigned WIDTH     = 16,
  parameter  bit          LSB_FIRST = 1'b1,
  localparam int unsigned CODE_W    = code_w(WIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_word,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_code,
  output logic              out_last,
  output logic              out_none,
  output logic [CODE_W:0]   word_cnt
);

  state_t            state_q;
  logic              ready_q;
  logic              zero_q;
  logic [WIDTH-1:0]  pending_q;
  logic [CODE_W:0]   word_cnt_q;
  logic [CODE_W-1:0] enc_code;
  logic              enc_any;
  logic              emitting;
  logic              single;
  logic              last;
  logic [WIDTH-1:0]  emit_mask;

  ffs_encoder #(.WIDTH(WIDTH)) u_ffs (
    .word      (pending_q),
    .lsb_first (LSB_FIRST),
    .code      (enc_code),
    .any       (enc_any)
  );

  always_comb begin
    emitting  = (state_q == EMIT);
    single    = enc_any && ((pending_q & (pending_q - WIDTH'(1))) == '0);
    last      = emitting && (zero_q || single);
    emit_mask = WIDTH'(1) << enc_code;
  end

  // in_ready is a register so it stays low through the reset cycle.
  assign in_ready  = ready_q;
  assign out_valid = emitting;
  assign out_code  = emitting ? enc_code : '0;
  assign out_last  = last;
  assign out_none  = emitting && zero_q;
  assign word_cnt  = word_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ready_q    <= 1'b0;
      zero_q     <= 1'b0;
      pending_q  <= '0;
      word_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          if (in_valid && ready_q) begin
            pending_q  <= in_word;
            word_cnt_q <= (CODE_W+1)'(popcount(wide_t'(in_word)));
            zero_q     <= (in_word == '0);
            state_q    <= EMIT;
            ready_q    <= 1'b0;
          end
        end
        EMIT: begin
          if (out_ready) begin
            pending_q <= pending_q & ~emit_mask;
            if (last) begin
              state_q <= IDLE;
              ready_q <= 1'b1;
              zero_q  <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  in_valid_known: assert property (@(posedge clk) disable iff (rst)
    (state_q == IDLE) |-> !$isunknown(in_valid));

endmodule

// File: tb/tb_seq_encoder_16to4.sv
// Directed bench for seq_encoder_16to4: a vector table of words with their
// expected beat sequences, plus hand-written stall, reset and back-to-back cases.
module tb_seq_encoder_16to4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_word = '0;
  logic        out_ready = 1'b1;

  logic        in_ready, out_valid, out_last, out_none;
  logic [3:0]  out_code;
  logic [4:0]  word_cnt;
  logic        m_in_ready, m_out_valid, m_out_last, m_out_none;
  logic [3:0]  m_out_code;
  logic [4:0]  m_word_cnt;

  int unsigned n_checks = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  seq_encoder_16to4 #(.WIDTH(16), .LSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
    .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
    .out_last(out_last), .out_none(out_none), .word_cnt(word_cnt)
  );

  seq_encoder_16to4 #(.WIDTH(16), .LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(m_in_ready), .in_word(in_word),
    .out_valid(m_out_valid), .out_ready(out_ready), .out_code(m_out_code),
    .out_last(m_out_last), .out_none(m_out_none), .word_cnt(m_word_cnt)
  );

  typedef struct {
    logic [15:0] word;
    int unsigned nbeats;
    logic [63:0] codes_lsb;  // beat i at [4*i +: 4]
    logic [63:0] codes_msb;
    logic [4:0]  cnt;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int unsigned t;
    t = 0;
    while (in_ready !== 1'b1 && t < 40) begin
      tick();
      t++;
    end
    check("ready_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic load(input logic [15:0] w);
    wait_ready();
    in_valid = 1'b1;
    in_word  = w;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    logic [3:0] exp_l, exp_m;
    out_ready = 1'b1;
    load(v.word);
    for (int unsigned b = 0; b < v.nbeats; b++) begin
      exp_l = v.codes_lsb[4*b +: 4];
      exp_m = v.codes_msb[4*b +: 4];
      check("vec_valid", 32'(out_valid), 32'd1);
      check("vec_ready_low", 32'(in_ready), 32'd0);
      check("vec_code", 32'(out_code), 32'(exp_l));
      check("vec_last", 32'(out_last), 32'(b == v.nbeats - 1));
      check("vec_none", 32'(out_none), 32'(v.word == 16'h0));
      check("vec_cnt", 32'(word_cnt), 32'(v.cnt));
      check("vec_msb_code", 32'(m_out_code), 32'(exp_m));
      check("vec_msb_last", 32'(m_out_last), 32'(b == v.nbeats - 1));
      tick();
    end
    check("vec_done_valid", 32'(out_valid), 32'd0);
    check("vec_done_ready", 32'(in_ready), 32'd1);
    check("vec_done_cnt_held", 32'(word_cnt), 32'(v.cnt));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] pat;
    int unsigned beat, cyc;

    vecs[0] = '{16'h0001, 1, 64'h0,    64'h0,    5'd1};
    vecs[1] = '{16'h8421, 4, 64'hFA50, 64'h05AF, 5'd4};
    vecs[2] = '{16'h0000, 1, 64'h0,    64'h0,    5'd0};
    vecs[3] = '{16'h8000, 1, 64'hF,    64'hF,    5'd1};
    vecs[4] = '{16'h00F0, 4, 64'h7654, 64'h4567, 5'd4};
    vecs[5] = '{16'h0100, 1, 64'h8,    64'h8,    5'd1};
    vecs[6] = '{16'h8001, 2, 64'hF0,   64'h0F,   5'd2};

    // reset state
    tick();
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_code", 32'(out_code), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_out_none", 32'(out_none), 32'd0);
    check("rst_word_cnt", 32'(word_cnt), 32'd0);
    rst = 1'b0;
    tick();
    check("post_rst_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // FFFF with out_ready pattern 1,0,0,1; in_valid held until the last beat
    pat = 4'b1001;
    wait_ready();
    in_valid = 1'b1;
    in_word  = 16'hFFFF;
    tick();
    beat = 0;
    cyc  = 0;
    while (beat < 16 && cyc < 200) begin
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_ready_low", 32'(in_ready), 32'd0);
      check("stall_code", 32'(out_code), beat);
      check("stall_last", 32'(out_last), 32'(beat == 15));
      check("stall_cnt", 32'(word_cnt), 32'd16);
      check("stall_msb_code", 32'(m_out_code), 32'(15 - beat));
      out_ready = pat[cyc % 4];
      if (beat == 15) in_valid = 1'b0;
      tick();
      if (out_ready) beat++;
      cyc++;
    end
    check("stall_beats", beat, 32'd16);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("stall_done_valid", 32'(out_valid), 32'd0);
    check("stall_done_ready", 32'(in_ready), 32'd1);

    // reset mid-word after the first beat of 00F0
    load(16'h00F0);
    check("mid_first_code", 32'(out_code), 32'd4);
    tick();
    check("mid_second_code", 32'(out_code), 32'd5);
    rst = 1'b1;
    tick();
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_code", 32'(out_code), 32'd0);
    check("mid_rst_last", 32'(out_last), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    tick();
    check("mid_after_ready", 32'(in_ready), 32'd1);
    check("mid_after_valid", 32'(out_valid), 32'd0);
    run_vec(vecs[5]);

    // back-to-back with in_valid held: 0003 then 0400
    wait_ready();
    in_valid = 1'b1;
    in_word  = 16'h0003;
    tick();
    in_word  = 16'h0400;
    check("b2b_code0", 32'(out_code), 32'd0);
    check("b2b_last0", 32'(out_last), 32'd0);
    check("b2b_cnt0", 32'(word_cnt), 32'd2);
    tick();
    check("b2b_code1", 32'(out_code), 32'd1);
    check("b2b_last1", 32'(out_last), 32'd1);
    tick();
    check("b2b_idle_valid", 32'(out_valid), 32'd0);
    check("b2b_idle_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("b2b_code2", 32'(out_code), 32'd10);
    check("b2b_last2", 32'(out_last), 32'd1);
    check("b2b_cnt2", 32'(word_cnt), 32'd1);
    tick();
    check("b2b_done_valid", 32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
